// File: rtl/tl_ul_arbiter_2to1.sv
// Two-master to one-slave TL-UL arbiter with a single transaction in flight.
// Channel A is granted round-robin, the grant is held until the matching D beat is accepted, and D is routed back to the owner.
module tl_ul_arbiter_2to1 #(
    parameter bit RR_FIRST = 1'b0,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SRC_W    = 8,
    parameter int SIZE_W   = 2
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    // requester 0
    input  logic                m0_a_valid,
    output logic                m0_a_ready,
    input  logic [2:0]          m0_a_opcode,
    input  logic [2:0]          m0_a_param,
    input  logic [SIZE_W-1:0]   m0_a_size,
    input  logic [SRC_W-1:0]    m0_a_source,
    input  logic [ADDR_W-1:0]   m0_a_address,
    input  logic [DATA_W/8-1:0] m0_a_mask,
    input  logic [DATA_W-1:0]   m0_a_data,
    output logic                m0_d_valid,
    input  logic                m0_d_ready,
    output logic [2:0]          m0_d_opcode,
    output logic [2:0]          m0_d_param,
    output logic [SIZE_W-1:0]   m0_d_size,
    output logic [SRC_W-1:0]    m0_d_source,
    output logic [DATA_W-1:0]   m0_d_data,
    output logic                m0_d_error,
    // requester 1
    input  logic                m1_a_valid,
    output logic                m1_a_ready,
    input  logic [2:0]          m1_a_opcode,
    input  logic [2:0]          m1_a_param,
    input  logic [SIZE_W-1:0]   m1_a_size,
    input  logic [SRC_W-1:0]    m1_a_source,
    input  logic [ADDR_W-1:0]   m1_a_address,
    input  logic [DATA_W/8-1:0] m1_a_mask,
    input  logic [DATA_W-1:0]   m1_a_data,
    output logic                m1_d_valid,
    input  logic                m1_d_ready,
    output logic [2:0]          m1_d_opcode,
    output logic [2:0]          m1_d_param,
    output logic [SIZE_W-1:0]   m1_d_size,
    output logic [SRC_W-1:0]    m1_d_source,
    output logic [DATA_W-1:0]   m1_d_data,
    output logic                m1_d_error,
    // memory controller slave
    output logic                s_a_valid,
    input  logic                s_a_ready,
    output logic [2:0]          s_a_opcode,
    output logic [2:0]          s_a_param,
    output logic [SIZE_W-1:0]   s_a_size,
    output logic [SRC_W-1:0]    s_a_source,
    output logic [ADDR_W-1:0]   s_a_address,
    output logic [DATA_W/8-1:0] s_a_mask,
    output logic [DATA_W-1:0]   s_a_data,
    input  logic                s_d_valid,
    output logic                s_d_ready,
    input  logic [2:0]          s_d_opcode,
    input  logic [2:0]          s_d_param,
    input  logic [SIZE_W-1:0]   s_d_size,
    input  logic [SRC_W-1:0]    s_d_source,
    input  logic [DATA_W-1:0]   s_d_data,
    input  logic                s_d_error,
    output logic                owner_o,
    output logic                busy_o
);
    localparam int MASK_W = DATA_W / 8;
    localparam int A_W    = 3 + 3 + SIZE_W + SRC_W + ADDR_W + MASK_W + DATA_W;

    typedef enum logic [1:0] {IDLE, A_PEND, WAIT_D} state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   prio_q, prio_d;
    logic   sel, a_sel, a_req, d_route, own_a_valid, own_d_ready;

    logic [A_W-1:0] m0_a_pkt, m1_a_pkt, s_a_pkt;

    assign m0_a_pkt = {m0_a_opcode, m0_a_param, m0_a_size, m0_a_source,
                       m0_a_address, m0_a_mask, m0_a_data};
    assign m1_a_pkt = {m1_a_opcode, m1_a_param, m1_a_size, m1_a_source,
                       m1_a_address, m1_a_mask, m1_a_data};
    assign s_a_pkt  = a_sel ? m1_a_pkt : m0_a_pkt;
    assign {s_a_opcode, s_a_param, s_a_size, s_a_source,
            s_a_address, s_a_mask, s_a_data} = s_a_pkt;

    // D payload is broadcast; only d_valid decides who actually sees a beat
    assign m0_d_opcode = s_d_opcode;
    assign m0_d_param  = s_d_param;
    assign m0_d_size   = s_d_size;
    assign m0_d_source = s_d_source;
    assign m0_d_data   = s_d_data;
    assign m0_d_error  = s_d_error;
    assign m1_d_opcode = s_d_opcode;
    assign m1_d_param  = s_d_param;
    assign m1_d_size   = s_d_size;
    assign m1_d_source = s_d_source;
    assign m1_d_data   = s_d_data;
    assign m1_d_error  = s_d_error;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        a_sel       = owner_q;
        a_req       = 1'b0;
        d_route     = 1'b0;
        sel         = (m0_a_valid && m1_a_valid) ? prio_q : m1_a_valid;
        own_a_valid = owner_q ? m1_a_valid : m0_a_valid;
        own_d_ready = owner_q ? m1_d_ready : m0_d_ready;
        case (state_q)
            IDLE: begin
                a_sel = sel;
                a_req = m0_a_valid || m1_a_valid;
                if (a_req) begin
                    owner_d = sel;
                    state_d = s_a_ready ? WAIT_D : A_PEND;
                end
            end
            A_PEND: begin
                a_req = own_a_valid;
                if (own_a_valid && s_a_ready) begin
                    state_d = WAIT_D;
                end
            end
            WAIT_D: begin
                d_route = 1'b1;
                if (s_d_valid && own_d_ready) begin
                    prio_d  = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // handshake outputs are held quiet while reset is asserted
    assign s_a_valid  = reset_ni && a_req;
    assign m0_a_ready = reset_ni && a_req && !a_sel && s_a_ready;
    assign m1_a_ready = reset_ni && a_req &&  a_sel && s_a_ready;
    assign s_d_ready  = reset_ni && d_route && own_d_ready;
    assign m0_d_valid = reset_ni && d_route && !owner_q && s_d_valid;
    assign m1_d_valid = reset_ni && d_route &&  owner_q && s_d_valid;
    assign owner_o    = owner_q;
    assign busy_o     = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            owner_q <= RR_FIRST;
            prio_q  <= RR_FIRST;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end
endmodule

// File: tb/tb_tl_ul_arbiter_2to1.sv
// Directed and randomized bench for tl_ul_arbiter_2to1, checked against a transaction-level model of the arbitration rules.
module tb_tl_ul_arbiter_2to1;
    localparam bit RR = 1'b0;

    logic clk_i = 1'b0;
    logic reset_ni;
    logic m0_a_valid, m0_a_ready, m0_d_valid, m0_d_ready, m0_d_error;
    logic m1_a_valid, m1_a_ready, m1_d_valid, m1_d_ready, m1_d_error;
    logic [2:0] m0_a_opcode, m0_a_param, m0_d_opcode, m0_d_param;
    logic [2:0] m1_a_opcode, m1_a_param, m1_d_opcode, m1_d_param;
    logic [1:0] m0_a_size, m0_d_size, m1_a_size, m1_d_size;
    logic [7:0] m0_a_source, m0_d_source, m1_a_source, m1_d_source;
    logic [31:0] m0_a_address, m0_a_data, m0_d_data, m1_a_address, m1_a_data, m1_d_data;
    logic [3:0] m0_a_mask, m1_a_mask;
    logic s_a_valid, s_a_ready, s_d_valid, s_d_ready, s_d_error;
    logic [2:0] s_a_opcode, s_a_param, s_d_opcode, s_d_param;
    logic [1:0] s_a_size, s_d_size;
    logic [7:0] s_a_source, s_d_source;
    logic [31:0] s_a_address, s_a_data, s_d_data;
    logic [3:0] s_a_mask;
    logic owner_o, busy_o;

    int vectors = 0;
    int miscompares = 0;

    // requester state (held until the A beat is accepted)
    logic        mv    [2];
    logic [2:0]  mop   [2];
    logic [31:0] maddr [2];
    logic [7:0]  msrc  [2];
    logic [31:0] mdat  [2];

    always #5 clk_i = ~clk_i;

    tl_ul_arbiter_2to1 #(.RR_FIRST(RR)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
        .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_source(m0_a_source),
        .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
        .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
        .m0_d_param(m0_d_param), .m0_d_size(m0_d_size), .m0_d_source(m0_d_source),
        .m0_d_data(m0_d_data), .m0_d_error(m0_d_error),
        .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
        .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_source(m1_a_source),
        .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
        .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
        .m1_d_param(m1_d_param), .m1_d_size(m1_d_size), .m1_d_source(m1_d_source),
        .m1_d_data(m1_d_data), .m1_d_error(m1_d_error),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
        .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
        .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
        .s_d_data(s_d_data), .s_d_error(s_d_error),
        .owner_o(owner_o), .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_ports();
        m0_a_valid = mv[0]; m0_a_opcode = mop[0]; m0_a_address = maddr[0];
        m0_a_source = msrc[0]; m0_a_data = mdat[0];
        m1_a_valid = mv[1]; m1_a_opcode = mop[1]; m1_a_address = maddr[1];
        m1_a_source = msrc[1]; m1_a_data = mdat[1];
    endtask

    task automatic set_m(input int m, input logic v, input logic [2:0] op,
                         input logic [31:0] addr, input logic [7:0] src, input logic [31:0] dat);
        mv[m] = v; mop[m] = op; maddr[m] = addr; msrc[m] = src; mdat[m] = dat;
        drive_ports();
    endtask

    task automatic set_d(input logic v, input logic [2:0] op, input logic [7:0] src, input logic [31:0] dat);
        s_d_valid = v; s_d_opcode = op; s_d_source = src; s_d_data = dat;
    endtask

    // transaction-level model and scoreboard state for the random phase
    logic       lock_m, out_m, lock_own, out_own, prio_m, g, anyreq, dr_own;
    logic       a0, a1, sa, d0, d1, sd, gen_en;
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];
    int         iss0, iss1, got0, got1;
    logic       sl_busy;
    int         sl_delay;
    logic [7:0] sl_src;
    logic [2:0] sl_op;

    initial begin
        reset_ni = 1'b0;
        for (int m = 0; m < 2; m++) set_m(m, 1'b0, 3'd4, 32'h0, 8'h0, 32'h0);
        m0_a_param = 3'd0; m1_a_param = 3'd0; m0_a_size = 2'd2; m1_a_size = 2'd2;
        m0_a_mask = 4'hF; m1_a_mask = 4'hF;
        m0_d_ready = 1'b0; m1_d_ready = 1'b0; s_a_ready = 1'b0;
        s_d_param = 3'd0; s_d_size = 2'd2; s_d_error = 1'b0;
        set_d(1'b1, 3'd1, 8'h0, 32'h0);
        tick(); tick();
        // reset state (a stray D beat must not reach a master)
        chk("rst_s_a_valid", s_a_valid, 0);
        chk("rst_m0_a_ready", m0_a_ready, 0);
        chk("rst_m1_a_ready", m1_a_ready, 0);
        chk("rst_m0_d_valid", m0_d_valid, 0);
        chk("rst_m1_d_valid", m1_d_valid, 0);
        chk("rst_s_d_ready", s_d_ready, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_owner", owner_o, RR);

        // single Get from m0, zero-latency A path, D one cycle later
        reset_ni = 1'b1;
        set_d(1'b0, 3'd0, 8'h0, 32'h0);
        set_m(0, 1'b1, 3'd4, 32'h100, 8'h05, 32'h0);
        s_a_ready = 1'b1;
        #1;
        chk("t1_s_a_valid", s_a_valid, 1);
        chk("t1_s_a_address", s_a_address, 32'h100);
        chk("t1_s_a_opcode", s_a_opcode, 3'd4);
        chk("t1_s_a_source", s_a_source, 8'h05);
        chk("t1_s_a_mask", s_a_mask, 4'hF);
        chk("t1_m0_a_ready", m0_a_ready, 1);
        chk("t1_m1_a_ready", m1_a_ready, 0);
        tick();
        set_m(0, 1'b0, 3'd4, 32'h100, 8'h05, 32'h0);
        set_d(1'b1, 3'd1, 8'h05, 32'hCAFE0100);
        m0_d_ready = 1'b1;
        #1;
        chk("t1_busy", busy_o, 1);
        chk("t1_owner", owner_o, 0);
        chk("t1_wait_s_a_valid", s_a_valid, 0);
        chk("t1_m0_d_valid", m0_d_valid, 1);
        chk("t1_m0_d_opcode", m0_d_opcode, 3'd1);
        chk("t1_m0_d_data", m0_d_data, 32'hCAFE0100);
        chk("t1_m0_d_source", m0_d_source, 8'h05);
        chk("t1_m1_d_valid", m1_d_valid, 0);
        chk("t1_s_d_ready", s_d_ready, 1);
        tick();
        set_d(1'b0, 3'd0, 8'h0, 32'h0);
        #1;
        chk("t1_idle_busy", busy_o, 0);

        // continuous contention right after reset: grants alternate
        reset_ni = 1'b0;
        tick();
        reset_ni = 1'b1;
        m1_d_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            logic exp_own;
            exp_own = (r % 2 == 1) ^ RR;
            set_m(0, 1'b1, 3'd4, 32'h200, 8'h01, 32'h0);
            set_m(1, 1'b1, 3'd4, 32'h300, 8'h02, 32'h0);
            s_a_ready = 1'b1;
            #1;
            chk("t2_m0_a_ready", m0_a_ready, !exp_own);
            chk("t2_m1_a_ready", m1_a_ready, exp_own);
            chk("t2_s_a_address", s_a_address, exp_own ? 32'h300 : 32'h200);
            tick();
            set_d(1'b1, 3'd1, exp_own ? 8'h02 : 8'h01, 32'h0);
            #1;
            chk("t2_owner", owner_o, exp_own);
            chk("t2_m0_d_valid", m0_d_valid, !exp_own);
            chk("t2_m1_d_valid", m1_d_valid, exp_own);
            tick();
            set_d(1'b0, 3'd0, 8'h0, 32'h0);
        end

        // slave stalls A: grant stays locked on m0 while m1 starts requesting
        set_m(1, 1'b0, 3'd0, 32'h0, 8'h0, 32'h0);
        set_m(0, 1'b1, 3'd4, 32'h400, 8'h03, 32'h0);
        s_a_ready = 1'b0;
        #1;
        chk("t3_s_a_valid", s_a_valid, 1);
        chk("t3_m0_a_ready_stall", m0_a_ready, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) set_m(1, 1'b1, 3'd0, 32'h500, 8'h07, 32'hDEADBEEF);
            #1;
            chk("t3_busy", busy_o, 1);
            chk("t3_s_a_address", s_a_address, 32'h400);
            chk("t3_m1_a_ready", m1_a_ready, 0);
            tick();
        end
        s_a_ready = 1'b1;
        #1;
        chk("t3_m0_a_ready", m0_a_ready, 1);
        chk("t3_m1_a_ready_acc", m1_a_ready, 0);
        tick();
        set_m(0, 1'b0, 3'd4, 32'h0, 8'h0, 32'h0);
        set_d(1'b1, 3'd1, 8'h03, 32'h0);
        #1;
        chk("t3_wait_m1_a_ready", m1_a_ready, 0);
        chk("t3_wait_s_a_valid", s_a_valid, 0);
        chk("t3_m0_d_valid", m0_d_valid, 1);
        tick();
        set_d(1'b0, 3'd0, 8'h0, 32'h0);

        // m1 PutFullData with its D beat back-pressured for 5 cycles
        #1;
        chk("t4_s_a_valid", s_a_valid, 1);
        chk("t4_s_a_opcode", s_a_opcode, 3'd0);
        chk("t4_s_a_data", s_a_data, 32'hDEADBEEF);
        chk("t4_m1_a_ready", m1_a_ready, 1);
        tick();
        set_m(1, 1'b0, 3'd0, 32'h0, 8'h0, 32'h0);
        set_m(0, 1'b1, 3'd4, 32'h600, 8'h04, 32'h0);
        set_d(1'b1, 3'd0, 8'h07, 32'h0);
        m1_d_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_s_d_ready", s_d_ready, 0);
            chk("t4_busy", busy_o, 1);
            chk("t4_m1_d_valid", m1_d_valid, 1);
            chk("t4_s_a_valid", s_a_valid, 0);
            chk("t4_m0_a_ready", m0_a_ready, 0);
            tick();
        end
        m1_d_ready = 1'b1;
        #1;
        chk("t4_s_d_ready_hs", s_d_ready, 1);
        chk("t4_m1_d_source", m1_d_source, 8'h07);
        tick();
        set_d(1'b0, 3'd0, 8'h0, 32'h0);
        #1;
        chk("t4_idle_busy", busy_o, 0);
        chk("t4_next_s_a_address", s_a_address, 32'h600);
        tick();
        set_m(0, 1'b0, 3'd4, 32'h0, 8'h0, 32'h0);
        set_d(1'b1, 3'd1, 8'h04, 32'h0);
        tick();
        set_d(1'b0, 3'd0, 8'h0, 32'h0);

        // reset while m1 waits for D: transaction dropped, priority restored
        set_m(1, 1'b1, 3'd4, 32'h700, 8'h09, 32'h0);
        tick();
        set_m(1, 1'b0, 3'd4, 32'h0, 8'h0, 32'h0);
        #1;
        chk("t5_busy_before", busy_o, 1);
        chk("t5_owner_before", owner_o, 1);
        reset_ni = 1'b0;
        set_d(1'b1, 3'd1, 8'h09, 32'h0);
        #1;
        chk("t5_rst_m1_d_valid", m1_d_valid, 0);
        chk("t5_rst_s_d_ready", s_d_ready, 0);
        tick();
        reset_ni = 1'b1;
        #1;
        chk("t5_busy", busy_o, 0);
        chk("t5_owner", owner_o, RR);
        chk("t5_m0_d_valid", m0_d_valid, 0);
        chk("t5_m1_d_valid", m1_d_valid, 0);
        chk("t5_s_d_ready", s_d_ready, 0);
        chk("t5_s_a_valid", s_a_valid, 0);
        set_d(1'b0, 3'd0, 8'h0, 32'h0);
        set_m(0, 1'b1, 3'd4, 32'h800, 8'h0A, 32'h0);
        set_m(1, 1'b1, 3'd4, 32'h900, 8'h0B, 32'h0);
        #1;
        chk("t5_m0_a_ready", m0_a_ready, !RR);
        chk("t5_m1_a_ready", m1_a_ready, RR);
        tick();
        set_m(0, 1'b0, 3'd4, 32'h0, 8'h0, 32'h0);
        set_m(1, 1'b0, 3'd4, 32'h0, 8'h0, 32'h0);
        set_d(1'b1, 3'd1, 8'h0A, 32'h0);
        #1;
        chk("t5_m0_d_valid_after", m0_d_valid, 1);
        tick();
        set_d(1'b0, 3'd0, 8'h0, 32'h0);

        // random traffic against the model
        reset_ni = 1'b0;
        tick();
        reset_ni = 1'b1;
        lock_m = 1'b0; out_m = 1'b0; lock_own = 1'b0; out_own = 1'b0; prio_m = RR;
        iss0 = 0; iss1 = 0; got0 = 0; got1 = 0;
        sl_busy = 1'b0; sl_delay = 0; sl_src = 8'h0; sl_op = 3'd0;
        gen_en = 1'b1;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (cyc == 400) gen_en = 1'b0;
            for (int m = 0; m < 2; m++) begin
                if (gen_en && !mv[m] && $urandom_range(0, 2) != 0) begin
                    mv[m]    = 1'b1;
                    mop[m]   = $urandom_range(0, 1) ? 3'd4 : 3'd0;
                    maddr[m] = 32'h1000 * (m + 1) + ($urandom & 32'hFFC);
                    msrc[m]  = 8'($urandom);
                    mdat[m]  = $urandom;
                end
            end
            drive_ports();
            s_a_ready  = ($urandom_range(0, 2) != 0);
            m0_d_ready = 1'($urandom_range(0, 1));
            m1_d_ready = 1'($urandom_range(0, 1));
            set_d(sl_busy && sl_delay == 0, (sl_op == 3'd4) ? 3'd1 : 3'd0, sl_src, $urandom);
            #1;
            g = 1'b0; anyreq = 1'b0;
            dr_own = out_own ? m1_d_ready : m0_d_ready;
            if (out_m) begin
                chk("rnd_wait_s_a_valid", s_a_valid, 0);
                chk("rnd_m0_d_valid", m0_d_valid, s_d_valid && !out_own);
                chk("rnd_m1_d_valid", m1_d_valid, s_d_valid && out_own);
                chk("rnd_s_d_ready", s_d_ready, dr_own);
            end else begin
                chk("rnd_idle_m0_d_valid", m0_d_valid, 0);
                chk("rnd_idle_m1_d_valid", m1_d_valid, 0);
                chk("rnd_idle_s_d_ready", s_d_ready, 0);
                if (lock_m) g = lock_own;
                else if (mv[0] && mv[1]) g = prio_m;
                else g = mv[1];
                anyreq = lock_m ? mv[g] : (mv[0] || mv[1]);
                chk("rnd_s_a_valid", s_a_valid, anyreq);
                if (anyreq) begin
                    chk("rnd_s_a_address", s_a_address, maddr[g]);
                    chk("rnd_s_a_source", s_a_source, msrc[g]);
                    chk("rnd_s_a_opcode", s_a_opcode, mop[g]);
                end
                chk("rnd_m0_a_ready", m0_a_ready, anyreq && !g && s_a_ready);
                chk("rnd_m1_a_ready", m1_a_ready, anyreq && g && s_a_ready);
            end
            a0 = m0_a_valid && m0_a_ready; a1 = m1_a_valid && m1_a_ready;
            sa = s_a_valid && s_a_ready;
            d0 = m0_d_valid && m0_d_ready; d1 = m1_d_valid && m1_d_ready;
            sd = s_d_valid && s_d_ready;
            if (sa) begin
                chk("rnd_single_outstanding", sl_busy, 0);
                sl_busy = 1'b1; sl_delay = $urandom_range(0, 3);
                sl_src = s_a_source; sl_op = s_a_opcode;
            end else if (sd) begin
                sl_busy = 1'b0;
            end else if (sl_busy && sl_delay > 0) begin
                sl_delay--;
            end
            if (a0) begin exp_q0.push_back(msrc[0]); mv[0] = 1'b0; iss0++; end
            if (a1) begin exp_q1.push_back(msrc[1]); mv[1] = 1'b0; iss1++; end
            if (d0) begin
                got0++;
                chk("rnd_m0_d_expected", exp_q0.size() != 0, 1);
                if (exp_q0.size() != 0) chk("rnd_m0_d_source", m0_d_source, exp_q0.pop_front());
            end
            if (d1) begin
                got1++;
                chk("rnd_m1_d_expected", exp_q1.size() != 0, 1);
                if (exp_q1.size() != 0) chk("rnd_m1_d_source", m1_d_source, exp_q1.pop_front());
            end
            if (out_m) begin
                if (s_d_valid && dr_own) begin
                    out_m = 1'b0;
                    prio_m = ~out_own;
                end
            end else if (anyreq) begin
                if (s_a_ready) begin
                    out_m = 1'b1; out_own = g; lock_m = 1'b0;
                end else begin
                    lock_m = 1'b1; lock_own = g;
                end
            end
            tick();
        end
        chk("rnd_m0_all_answered", got0, iss0);
        chk("rnd_m1_all_answered", got1, iss1);
        chk("rnd_m0_traffic_seen", iss0 > 10, 1);
        chk("rnd_m1_traffic_seen", iss1 > 10, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
